// File: rtl/fwft_word_packer.sv
// Packs LANES consecutive words from an FWFT FIFO read port into one wide
// valid/ready word, emitting partial words on flush or after an idle timeout.
module fwft_word_packer #(
  parameter int IN_WIDTH = 8,
  parameter int LANES    = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fifo_has_data,
  input  logic [IN_WIDTH-1:0]       fifo_rd_data,
  output logic                      fifo_rd_en,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IN_WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]          m_keep
);

  localparam int CW = $clog2(LANES + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LANES);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [LANES-1:0][IN_WIDTH-1:0] acc;
  logic [CW-1:0]                  cnt;
  logic [IW-1:0]                  idle;

  logic                           out_free;
  logic                           full;
  logic                           timeout_hit;
  logic                           emit;
  logic                           pop;
  logic [CW-1:0]                  lane_sel;
  logic [IN_WIDTH*LANES-1:0]      emit_data;
  logic [LANES-1:0]               emit_keep;

  assign out_free    = !m_valid || m_ready;
  assign full        = (cnt == FULL_CNT);
  assign timeout_hit = (TIMEOUT > 0) && (idle == IDLE_MAX);
  assign emit        = out_free && (full || ((cnt != '0) && (flush || timeout_hit)));
  assign pop         = fifo_has_data && (!full || emit);
  assign fifo_rd_en  = rst_n && pop;
  // A word popped in the emitting cycle always starts the next word.
  assign lane_sel    = emit ? '0 : cnt;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    emit_data = '0;
    emit_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      emit_keep[i] = (CW'(i) < cnt);
      if (emit_keep[i]) emit_data[i*IN_WIDTH +: IN_WIDTH] = acc[i];
    end
  end

  // NOTE: the accumulator is a data store without reset; cnt alone marks which
  // lanes are meaningful, and stale lanes are masked to zero on emit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (pop && (lane_sel == CW'(i))) acc[i] <= fifo_rd_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idle    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else begin
      if (emit) begin
        m_data  <= emit_data;
        m_keep  <= emit_keep;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (emit)     cnt <= pop ? CW'(1) : '0;
      else if (pop) cnt <= cnt + 1'b1;

      if (pop || emit || (cnt == '0) || full) idle <= '0;
      else if (idle != IDLE_MAX)              idle <= idle + 1'b1;
    end
  end

endmodule
